// File: rtl/fft_frame_arbiter_pkg.sv
// Shared types and constants for the FFT frame arbiter and related schedulers.
package fft_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } arb_state_t;

  localparam int unsigned FRAMES_DONE_W = 16;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_advance(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fft_frame_arbiter_if.sv
// Requester / engine handshake bundle around the FFT frame arbiter.
interface fft_frame_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 64
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;

  logic                           eng_in_valid;
  logic [DATA_W-1:0]              eng_in_data;
  logic                           eng_in_ready;

  logic                           eng_out_valid;
  logic [DATA_W-1:0]              eng_out_data;
  logic                           eng_out_ready;

  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic [NUM_REQ-1:0]             rsp_ready;

  // Arbiter side
  modport master (
    input  req_valid, req_data, eng_in_ready, eng_out_valid, eng_out_data, rsp_ready,
    output req_ready, eng_in_valid, eng_in_data, eng_out_ready, rsp_valid, rsp_data
  );

  // Requester / engine side
  modport slave (
    output req_valid, req_data, eng_in_ready, eng_out_valid, eng_out_data, rsp_ready,
    input  req_ready, eng_in_valid, eng_in_data, eng_out_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/fft_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after start.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  // Scan N positions starting at start, wrapping modulo N; lowest offset wins.
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cidx;
    hit  = 1'b0;
    idx  = '0;
    cand = 0;
    cidx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(start) + i) % N;
      cidx = IDX_W'(cand);
      if (!hit && req[cidx]) begin
        hit = 1'b1;
        idx = cidx;
      end
    end
  end

endmodule

// File: rtl/fft_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one FFT engine between requesters.
module fft_frame_arbiter
  import fft_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned FRAME_WORDS = 128,
  parameter int unsigned DATA_W      = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fft_frame_arbiter_if.master        bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [FRAMES_DONE_W-1:0]   frames_done
);

  localparam int unsigned ID_W      = $clog2(NUM_REQ);
  localparam int unsigned WC_W      = $clog2(FRAME_WORDS);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_WORDS - 1);

  arb_state_t               state;
  logic [ID_W-1:0]          rr_ptr;
  logic [WC_W-1:0]          word_cnt;
  logic [FRAMES_DONE_W-1:0] frames_cnt;

  logic                     pick_hit;
  logic [ID_W-1:0]          pick_idx;
  logic                     in_hs;
  logic                     out_hs;
  logic [DATA_W-1:0]        feed_word;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (bus.req_valid),
    .start (rr_ptr),
    .idx   (pick_idx),
    .hit   (pick_hit)
  );

  // Zero-latency steering of the granted requester onto the engine ports.
  always_comb begin
    bus.req_ready     = '0;
    bus.eng_in_valid  = 1'b0;
    bus.eng_out_ready = 1'b0;
    bus.rsp_valid     = '0;
    bus.rsp_data      = '0;
    feed_word         = '0;
    in_hs             = 1'b0;
    out_hs            = 1'b0;
    case (state)
      S_FEED: begin
        bus.eng_in_valid        = bus.req_valid[grant_id];
        feed_word               = bus.req_data[grant_id];
        bus.req_ready[grant_id] = bus.eng_in_ready;
        in_hs                   = bus.req_valid[grant_id] & bus.eng_in_ready;
      end
      S_DRAIN: begin
        bus.rsp_valid[grant_id] = bus.eng_out_valid;
        bus.rsp_data            = bus.eng_out_data;
        bus.eng_out_ready       = bus.rsp_ready[grant_id];
        out_hs                  = bus.eng_out_valid & bus.rsp_ready[grant_id];
      end
      default: ;
    endcase
  end

  assign bus.eng_in_data = feed_word;
  assign busy            = (state != S_IDLE);
  assign frames_done     = frames_cnt;

  // Frame FSM: arbitrate, feed one frame in, drain one frame out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      word_cnt   <= '0;
      frames_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_hit) begin
            grant_id <= pick_idx;
            word_cnt <= '0;
            rr_ptr   <= ID_W'(rr_advance(32'(pick_idx), NUM_REQ));
            state    <= S_FEED;
          end
        end
        S_FEED: begin
          if (in_hs) begin
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              state    <= S_DRAIN;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_hs) begin
            if (word_cnt == LAST_WORD) begin
              word_cnt   <= '0;
              frames_cnt <= frames_cnt + 1'b1;
              state      <= S_IDLE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_frame_arbiter.md
# fft_frame_arbiter

Frame-granular round-robin arbiter that shares one FFT stage engine (128-word consume/produce frame interface, `decoupled_vr` valid/ready) between `NUM_REQ` requester streams. It sits between the requesters' FIFO controllers and the engine's consumer/producer ports. It locks a grant for one complete frame: `FRAME_WORDS` input words in, then `FRAME_WORDS` result words out. It returns every result word to the requester that supplied the frame.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `FRAME_WORDS`, 128: words per frame, each direction; must match the engine.
- `DATA_W`, 64: word width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  `NUM_REQ`  per-requester input word valid.
- `req_data`  in  `NUM_REQ`×`DATA_W`  per-requester input word.
- `req_ready`  out  `NUM_REQ`  per-requester input accept.
- `eng_in_valid`  out  1  word valid toward the engine consumer port.
- `eng_in_data`  out  `DATA_W`  word toward the engine.
- `eng_in_ready`  in  1  engine accepts the word.
- `eng_out_valid`  in  1  engine result word valid.
- `eng_out_data`  in  `DATA_W`  engine result word.
- `eng_out_ready`  out  1  arbiter accepts the result word.
- `rsp_valid`  out  `NUM_REQ`  per-requester result valid.
- `rsp_data`  out  `DATA_W`  result word, shared by all requesters.
- `rsp_ready`  in  `NUM_REQ`  per-requester result accept.
- `grant_id`  out  `$clog2(NUM_REQ)`  current or last granted requester.
- `busy`  out  1  high whenever state is not S_IDLE.
- `frames_done`  out  16  completed-frame count; wraps.

## Operation
- States:
  - S_IDLE: no grant active.
  - S_FEED: forwarding the granted requester's input words to the engine.
  - S_DRAIN: returning the engine's result words to the granted requester.
- S_IDLE:
  - Pick the first index at or after `rr_ptr` (modulo `NUM_REQ`) whose `req_valid` is high.
  - On a hit, register `grant_id`, clear `word_cnt`, set `rr_ptr` = winner+1 mod `NUM_REQ`, and go to S_FEED.
  - With no valid request, stay in S_IDLE.
- S_FEED, combinational pass-through:
  - `eng_in_valid`=`req_valid[grant_id]`, `eng_in_data`=`req_data[grant_id]`.
  - `req_ready[grant_id]`=`eng_in_ready`; every other `req_ready` is 0.
  - Each handshake increments `word_cnt`.
  - The handshake with `word_cnt`==`FRAME_WORDS`-1 clears `word_cnt` and moves to S_DRAIN.
- S_DRAIN:
  - `rsp_valid[grant_id]`=`eng_out_valid`, `rsp_data`=`eng_out_data`, `eng_out_ready`=`rsp_ready[grant_id]`.
  - Each handshake increments `word_cnt`.
  - The last handshake increments `frames_done` and returns to S_IDLE.
- `eng_out_ready` is 0 outside S_DRAIN; engine output is back-pressured, never dropped.
- `eng_in_valid` is 0 outside S_FEED.
- `rsp_data` is 0 outside S_DRAIN.
- Non-granted requesters always see `req_ready`=0 and `rsp_valid`=0.
- A requester that drops `req_valid` mid-frame stalls the frame; the grant is held and there is no timeout.
- `word_cnt` is `$clog2(FRAME_WORDS)` bits wide. It never wraps within a state because it is cleared on each transition.

## Timing
- Reset values: state S_IDLE, `rr_ptr`=0, `grant_id`=0, `word_cnt`=0, `frames_done`=0. All outputs are 0: `req_ready`, `rsp_valid`, `eng_in_valid`, `eng_out_ready`, `busy`, `rsp_data`, `eng_in_data`.
- Grant latency:
  - `req_valid` high in S_IDLE at cycle t gives S_FEED at t+1.
  - The first word can transfer at t+1.
- Data paths are zero-latency: no registers between the requester and engine ports in either direction.
- Frame turnaround:
  - The last DRAIN handshake at cycle t gives S_IDLE at t+1 and the next grant at t+2.
  - There is a one-cycle arbitration bubble per frame.
- Fairness with all requesters continuously valid: grants rotate 0,1,...,`NUM_REQ`-1,0 and so on.
- Reset asserted mid-frame aborts immediately to reset values. The engine shares `rst_n` and must discard its partial frame.

## Structure
- Shared package `fft_arb_pkg`:
  - `arb_state_t` enum {S_IDLE, S_FEED, S_DRAIN}.
  - Constant `FRAMES_DONE_W`=16.
- Sub-module `rr_pick`: purely combinational. Inputs are a request vector and a start pointer; outputs are a one-hot/index winner and a hit flag. It is reusable by other acc_unit schedulers.
- Top level holds the FSM, counters and muxes.

## Test plan
- Single frame: requester 0 sends 128 words 0..127 with the engine always ready, and the engine returns x+1000. Required: 128 `rsp_valid[0]` beats 1000..1127, `frames_done`=1, `busy` low after the last beat, `rsp_valid[1]` never asserted.
- Contention: both requesters valid from reset. Required grant order 0,1,0,1 over 4 frames, no interleaving of words within a frame, `frames_done`=4.
- Back-pressure: `eng_in_ready` and `rsp_ready[1]` toggle randomly at 50%. Required: no lost or duplicated words, and the engine result is held stable while `eng_out_ready`=0.
- Requester stall: requester 1 drops `req_valid` for 20 cycles after word 60. Required: stays in S_FEED with `grant_id`=1, requester 0 sees `req_ready`=0 throughout, and the frame completes with `word_cnt` correct.
- Reset mid-DRAIN at word 50. Required: all outputs 0 in the same cycle reset asserts, `frames_done`=0, and the next request is granted to requester 0.
- `frames_done` wrap: preload to 16'hFFFF via force, complete one frame. Required: `frames_done`=0.
